// File: rtl/wait_timer_pkg.sv
// Shared definitions for wait_timer: state encodings and the default counter width.
package wait_timer_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wait_down_counter.sv
// Loadable down-counter with zero flag; clear beats load, load beats decrement.
module wait_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - WIDTH'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wait_timer.sv
// Programmable one-shot/periodic delay timer with kill and remaining-count readback.
// Optional pause support is enabled by defining WAIT_TIMER_PAUSE_EN.
module wait_timer
    import wait_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic             kill,
    input  logic             periodic,
    input  logic [WIDTH-1:0] wait_cycles,
    input  logic             pause,
    output logic             idle,
    output logic             done,
    output logic             killed,
    output logic [WIDTH-1:0] remaining
);

    state_t           state, state_nxt;
    logic             cnt_load, cnt_dec, cnt_clear, cnt_zero;
    logic [WIDTH-1:0] count;
    logic             killed_nxt;
    logic             hold;
    logic             n_nonzero;

`ifdef WAIT_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0 & pause;
`endif

    assign n_nonzero = (wait_cycles != '0);

    wait_down_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (wait_cycles - WIDTH'(1)),
        .en       (cnt_dec),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            killed <= 1'b0;
        end else begin
            state  <= state_nxt;
            killed <= killed_nxt;
        end
    end

    // kill is checked first in WAIT/DONE so it overrides completion and reload
    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clear  = 1'b0;
        killed_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    if (n_nonzero) begin
                        state_nxt = ST_WAIT;
                        cnt_load  = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (kill) begin
                    state_nxt  = ST_IDLE;
                    cnt_clear  = 1'b1;
                    killed_nxt = 1'b1;
                end else if (!hold) begin
                    if (cnt_zero)
                        state_nxt = ST_DONE;
                    else
                        cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (kill) begin
                    state_nxt  = ST_IDLE;
                    cnt_clear  = 1'b1;
                    killed_nxt = 1'b1;
                end else if (periodic) begin
                    if (n_nonzero) begin
                        state_nxt = ST_WAIT;
                        cnt_load  = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    assign idle      = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    assign remaining = (state == ST_WAIT) ? count : '0;

endmodule

// File: tb/tb_wait_timer.sv
// Directed self-checking bench for wait_timer (default WIDTH=8).
module tb_wait_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       go = 1'b0;
    logic       kill = 1'b0;
    logic       periodic = 1'b0;
    logic [7:0] wait_cycles = 8'd0;
    logic       pause = 1'b0;
    logic       idle, done, killed;
    logic [7:0] remaining;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wait_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .kill        (kill),
        .periodic    (periodic),
        .wait_cycles (wait_cycles),
        .pause       (pause),
        .idle        (idle),
        .done        (done),
        .killed      (killed),
        .remaining   (remaining)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({idle, done, killed, remaining} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
                errors++;
                $display("FAIL reset_hold: idle=%b done=%b killed=%b rem=%0d, want 1 0 0 0", idle, done, killed, remaining);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({idle, done, killed, remaining} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
                errors++;
                $display("FAIL reset_release: idle=%b done=%b killed=%b rem=%0d, want 1 0 0 0", idle, done, killed, remaining);
            end
        end
    endtask

    task automatic test_oneshot();
        wait_cycles = 8'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (remaining !== 8'(4 - k) || done !== 1'b0 || idle !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_count[%0d]: rem=%0d done=%b idle=%b, want rem=%0d done=0 idle=0", k, remaining, done, idle, 4 - k);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL oneshot_done: done=%b rem=%0d, want 1 0", done, remaining);
        end
        tick();
        checks++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_idle: idle=%b done=%b, want 1 0", idle, done);
        end
    endtask

    task automatic test_kill();
        wait_cycles = 8'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        checks++;
        if (remaining !== 8'd2) begin
            errors++;
            $display("FAIL kill_pre: rem=%0d, want 2", remaining);
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++;
        if (killed !== 1'b1 || idle !== 1'b1 || done !== 1'b0 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL kill_wait: killed=%b idle=%b done=%b rem=%0d, want 1 1 0 0", killed, idle, done, remaining);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (killed !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL kill_after[%0d]: killed=%b done=%b, want 0 0", i, killed, done);
            end
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++;
        if (killed !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL kill_idle: killed=%b idle=%b, want 0 1", killed, idle);
        end
    endtask

    task automatic test_periodic();
        wait_cycles = 8'd3;
        periodic = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int t = 0; t < 12; t++) begin
            checks++;
            if (done !== ((t % 4) == 3)) begin
                errors++;
                $display("FAIL periodic_done[t=%0d]: done=%b, want %b", t, done, (t % 4) == 3);
            end
            if (t == 11) periodic = 1'b0;
            tick();
        end
        checks++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL periodic_stop: idle=%b done=%b, want 1 0", idle, done);
        end
        // kill at remaining==0 must suppress done
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        checks++;
        if (remaining !== 8'd0 || idle !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL kill_zero_pre: rem=%0d idle=%b done=%b, want 0 0 0", remaining, idle, done);
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++;
        if (done !== 1'b0 || killed !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL kill_zero: done=%b killed=%b idle=%b, want 0 1 1", done, killed, idle);
        end
        // kill in DONE beats the periodic reload
        wait_cycles = 8'd1;
        periodic = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL kill_done_pre: done=%b, want 1", done);
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        periodic = 1'b0;
        checks++;
        if (killed !== 1'b1 || idle !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL kill_done: killed=%b idle=%b done=%b, want 1 1 0", killed, idle, done);
        end
        tick();
    endtask

    task automatic test_edges();
        int n;
        wait_cycles = 8'd0;
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (done !== 1'b1 || idle !== 1'b0 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL n0_done: done=%b idle=%b rem=%0d, want 1 0 0", done, idle, remaining);
        end
        tick();
        checks++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL n0_idle: idle=%b done=%b, want 1 0", idle, done);
        end
        // periodic with N=0 holds done high
        periodic = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL n0_periodic[%0d]: done=%b, want 1", i, done);
            end
        end
        periodic = 1'b0;
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL n0_periodic_stop: idle=%b, want 1", idle);
        end
        // maximum delay
        wait_cycles = 8'd255;
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (remaining !== 8'd254) begin
            errors++;
            $display("FAIL n255_start: rem=%0d, want 254", remaining);
        end
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 255) begin
            errors++;
            $display("FAIL n255_latency: got %0d cycles, want 255", n);
        end
        tick();
        // wait_cycles and go changes mid-wait are ignored
        wait_cycles = 8'd6;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        wait_cycles = 8'd2;
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 2;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL midwait_change: got %0d cycles, want 6", n);
        end
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL midwait_idle: idle=%b, want 1", idle);
        end
    endtask

    task automatic test_pause();
        int n;
        int exp_n;
`ifdef WAIT_TIMER_PAUSE_EN
        exp_n = 7;
`else
        exp_n = 4;
`endif
        wait_cycles = 8'd4;
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            pause = (n >= 1 && n <= 3);
            tick();
            n++;
        end
        pause = 1'b0;
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL pause_latency: got %0d cycles, want %0d", n, exp_n);
        end
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL pause_idle: idle=%b, want 1", idle);
        end
    endtask

    task automatic test_reset_mid();
        wait_cycles = 8'd10;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #2;
        checks++;
        if (idle !== 1'b1 || remaining !== 8'd0 || done !== 1'b0 || killed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: idle=%b rem=%0d done=%b killed=%b, want 1 0 0 0", idle, remaining, done, killed);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || killed !== 1'b0 || idle !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: done=%b killed=%b idle=%b, want 0 0 1", i, done, killed, idle);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_kill();
        test_periodic();
        test_edges();
        test_pause();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
